// File: rtl/fp32_pkg.sv
// fp32_pkg
//   Shared fp32 constants, field-extract helpers and the controller state type
//   for the clip-space perspective-divide block.
//   No ports (package).
package fp32_pkg;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  // One quotient bit per DIV cycle: integer bit plus 24 fraction bits.
  localparam int          RECIP_STEPS  = 25;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    MUL,
    OUT
  } pdiv_state_t;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp_man(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/fp32_mul.sv
// fp32_mul
//   Combinational fp32 multiplier, round toward zero, denormal inputs
//   flushed to zero, underflow to signed zero, overflow to signed infinity.
//   Ports:
//     a, b : fp32 operands
//     p    : fp32 product
module fp32_mul
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic        s;
  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [24:0] prod_hi;
  logic [22:0] mant;
  logic [9:0]  e_sum;

  assign s      = fp_sign(a) ^ fp_sign(b);
  assign ea     = fp_exp(a);
  assign eb     = fp_exp(b);
  assign a_nan  = (ea == 8'hFF) && (fp_man(a) != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fp_man(b) != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fp_man(a) == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fp_man(b) == 23'd0);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  // Only the top 25 bits of the 48-bit significand product matter under truncation.
  assign prod_hi = 25'((48'({1'b1, fp_man(a)}) * 48'({1'b1, fp_man(b)})) >> 23);
  assign mant    = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
  assign e_sum   = {2'b00, ea} + {2'b00, eb} - 10'(FP32_BIAS) + {9'd0, prod_hi[24]};

  always_comb begin
    p = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      p = FP32_QNAN;
    end else if (a_inf || b_inf) begin
      p = FP32_POS_INF | {s, 31'd0};
    end else if (a_zero || b_zero) begin
      p = {s, 31'd0};
    end else if (e_sum[9] || (e_sum == 10'd0)) begin
      p = {s, 31'd0};
    end else if (e_sum >= 10'd255) begin
      p = FP32_POS_INF | {s, 31'd0};
    end else begin
      p = {s, e_sum[7:0], mant};
    end
  end

endmodule

// File: rtl/fp32_recip_iter.sv
// fp32_recip_iter
//   Fixed-latency fp32 reciprocal: restoring division of 1.0 by the operand
//   significand, one quotient bit per cycle, 25 cycles regardless of operand.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     start    : latch operand and begin (ignored while busy)
//     operand  : fp32 divisor
//     busy     : iteration in progress
//     done     : high in the final iteration cycle
//     result   : fp32 1/operand, valid once busy has dropped
//     is_zero  : operand exponent field is zero (zero or denormal)
module fp32_recip_iter
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        is_zero
);

  logic [31:0] op_q;
  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [24:0] quo;
  logic [23:0] divisor;
  logic        rem_ge;
  logic [23:0] rem_sub;

  logic        s;
  logic [7:0]  e;
  logic [22:0] m;
  logic [9:0]  field;
  logic [22:0] mant;

  assign s       = fp_sign(op_q);
  assign e       = fp_exp(op_q);
  assign m       = fp_man(op_q);
  assign divisor = {1'b1, m};
  assign rem_ge  = rem >= {1'b0, divisor};
  // After a successful subtract the remainder is below the divisor, so 24 bits suffice.
  assign rem_sub = 24'(rem - {1'b0, divisor});

  assign done    = busy && (cnt == 5'(RECIP_STEPS - 1));
  assign is_zero = (e == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      op_q <= operand;
      cnt  <= '0;
      rem  <= 25'h080_0000;  // 1.0 at the divisor's scale
      quo  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (rem_ge) begin
        rem <= {rem_sub, 1'b0};
        quo <= {quo[23:0], 1'b1};
      end else begin
        rem <= {rem[23:0], 1'b0};
        quo <= {quo[23:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

  // quo[24] is set only for a 1.0 significand; otherwise the quotient lies in
  // (0.5, 1) and is normalised left by one, costing one exponent step.
  always_comb begin
    field = '0;
    mant  = '0;
    if (quo[24]) begin
      field = 10'(2 * FP32_BIAS) - {2'b00, e};
      mant  = quo[23:1];
    end else begin
      field = 10'(2 * FP32_BIAS - 1) - {2'b00, e};
      mant  = quo[22:0];
    end
  end

  always_comb begin
    result = '0;
    if (e == 8'd0) begin
      result = FP32_POS_INF | {s, 31'd0};
    end else if (e == 8'hFF) begin
      result = (m != 23'd0) ? FP32_QNAN : {s, 31'd0};
    end else if (field[9] || (field == 10'd0)) begin
      result = {s, 31'd0};
    end else begin
      result = {s, field[7:0], mant};
    end
  end

endmodule

// File: rtl/clip_persp_div_fp32.sv
// clip_persp_div_fp32
//   Perspective divide: buffers clip-space vertices in a small FIFO, computes
//   1/w iteratively, then multiplies x, y, z by 1/w to produce NDC output.
//
//   state | meaning
//   IDLE  | waiting for a buffered vertex; pops it and starts the reciprocal
//   DIV   | reciprocal iterating (25 cycles)
//   MUL   | three multiplies registered into the outputs
//   OUT   | out_valid held until out_ready
//
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     in_valid           : vertex present (no upstream stall)
//     cx, cy, cz, cw     : clip-space fp32 vertex
//     in_ready           : FIFO not full
//     overflow           : sticky, a vertex was dropped on a full FIFO
//     out_valid          : result held on outputs
//     out_ready          : downstream accepts
//     nx, ny, nz         : cx/cw, cy/cw, cz/cw
//     w_inv              : fp32 1/cw
//     w_zero             : cw was zero or denormal
module clip_persp_div_fp32
  import fp32_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] cx,
  input  logic [31:0] cy,
  input  logic [31:0] cz,
  input  logic [31:0] cw,
  output logic        in_ready,
  output logic        overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] nx,
  output logic [31:0] ny,
  output logic [31:0] nz,
  output logic [31:0] w_inv,
  output logic        w_zero
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [127:0] mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty, push, pop;
  logic [127:0] head;

  pdiv_state_t  state, state_next;
  logic [31:0]  vx, vy, vz;

  logic         recip_busy, recip_done, recip_zero;
  logic [31:0]  recip_res;
  logic [31:0]  px, py, pz;

  // Full is judged on the registered pointers, so a same-cycle pop never frees a slot for a push.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty && !recip_busy;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign in_ready = !full;
  assign out_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cx, cy, cz, cw};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = DIV;
      DIV:     if (recip_done) state_next = MUL;
      MUL:     state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vx <= '0;
      vy <= '0;
      vz <= '0;
    end else if (pop) begin
      vx <= head[127:96];
      vy <= head[95:64];
      vz <= head[63:32];
    end
  end

  fp32_recip_iter u_recip (
    .clk     (clk),
    .rst     (rst),
    .start   (pop),
    .operand (head[31:0]),
    .busy    (recip_busy),
    .done    (recip_done),
    .result  (recip_res),
    .is_zero (recip_zero)
  );

  fp32_mul u_mul_x (.a(vx), .b(recip_res), .p(px));
  fp32_mul u_mul_y (.a(vy), .b(recip_res), .p(py));
  fp32_mul u_mul_z (.a(vz), .b(recip_res), .p(pz));

  // A finite reciprocal never has an all-ones exponent, so QNAN here means cw was NaN.
  always_ff @(posedge clk) begin
    if (rst) begin
      nx     <= '0;
      ny     <= '0;
      nz     <= '0;
      w_inv  <= '0;
      w_zero <= 1'b0;
    end else if (state == MUL) begin
      w_inv  <= recip_res;
      w_zero <= recip_zero;
      if (recip_zero) begin
        nx <= '0;
        ny <= '0;
        nz <= '0;
      end else if (recip_res == FP32_QNAN) begin
        nx <= FP32_QNAN;
        ny <= FP32_QNAN;
        nz <= FP32_QNAN;
      end else begin
        nx <= px;
        ny <= py;
        nz <= pz;
      end
    end
  end

endmodule
